uart_tx_feeder: RTL and testbench

Byte FIFO and start sequencer placed directly upstream of the `Uart8` transmitter. Producers push bytes at clock rate through a valid/ready port. The block drains the FIFO one byte per frame, driving `Uart8`'s `txStart`/`in` and tracking `txBusy`. It replaces hand-timed `txStart`/`txByte` driving with a flow-controlled queue.

---
 rtl/uart_feeder_pkg.sv | 15 +
 rtl/uart_tx_feeder_byte_fifo.sv | 74 +++++++
 rtl/uart_tx_feeder.sv | 144 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_feeder_pkg.sv
// uart_feeder_pkg
// Shared types and constants for the UART transmit feeder.
//   feeder_state_t : sequencer states (IDLE -> START -> WAIT -> IDLE)
//   BYTE_W         : width of one transmitted byte
package uart_feeder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_byte_fifo.sv
// byte_fifo
// Circular byte queue with a separate occupancy counter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push, din  : write request and data (ignored while full)
//   pop        : remove head entry (ignored while empty)
//   dout       : current head entry, combinational from the read pointer
//   level      : occupancy, 0..DEPTH
//   full/empty : level==DEPTH / level==0
module byte_fifo
    import uart_feeder_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;

    logic w_do_push;
    logic w_do_pop;

    // Guard the requests locally so the counter can never leave 0..DEPTH,
    // whatever the caller does.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full  = (r_level == LVL_W'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;
    assign dout  = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Flow-controlled byte queue that feeds a Uart8 transmitter one frame at a time.
// Ports:
//   clk, reset      : clock (shared with Uart8) and synchronous active-high reset
//   wrValid/wrData  : producer byte; accepted when wrReady (= !full)
//   level/empty/full: FIFO occupancy status
//   overflow        : 1-cycle pulse after a write was attempted while full (byte dropped)
//   txStart/txByte  : drive Uart8.txStart / Uart8.in; txByte is held while txStart is high
//   txBusy          : Uart8.txBusy, same clock domain
//   sent            : 1-cycle pulse when a frame has finished
//   timeoutErr      : 1-cycle pulse when Uart8 never acknowledged a start
module uart_tx_feeder
    import uart_feeder_pkg::*;
#(
    parameter  int DEPTH         = 16,
    parameter  int START_TIMEOUT = 65535,
    localparam int LVL_W         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrValid,
    input  logic [BYTE_W-1:0] wrData,
    output logic              wrReady,
    output logic [LVL_W-1:0]  level,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              txStart,
    output logic [BYTE_W-1:0] txByte,
    input  logic              txBusy,
    output logic              sent,
    output logic              timeoutErr
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    // The counter starts at 0 on entry to START, so reaching this value
    // means txStart has been high for START_TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    feeder_state_t     r_state;
    feeder_state_t     w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [BYTE_W-1:0] r_tx_byte;
    logic [BYTE_W-1:0] w_tx_byte_next;
    logic              r_sent;
    logic              w_sent_next;
    logic              r_timeout_err;
    logic              w_timeout_err_next;
    logic              r_overflow;
    logic              w_pop;

    logic [BYTE_W-1:0] w_fifo_dout;
    logic [LVL_W-1:0]  w_fifo_level;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wrValid),
        .pop   (w_pop),
        .din   (wrData),
        .dout  (w_fifo_dout),
        .level (w_fifo_level),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_tx_byte_next     = r_tx_byte;
        w_sent_next        = 1'b0;
        w_timeout_err_next = 1'b0;
        w_pop              = 1'b0;

        case (r_state)
            IDLE: begin
                // A busy transmitter (e.g. a frame still running across a
                // reset) holds off the pop so the byte is not started early.
                if (!w_fifo_empty && !txBusy) begin
                    w_pop          = 1'b1;
                    w_tx_byte_next = w_fifo_dout;
                    w_cnt_next     = '0;
                    w_state_next   = START;
                end
            end
            START: begin
                // Acknowledge wins over a timeout landing in the same cycle.
                if (txBusy) begin
                    w_cnt_next   = '0;
                    w_state_next = WAIT;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_next         = '0;
                    w_timeout_err_next = 1'b1;
                    w_state_next       = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                if (!txBusy) begin
                    w_sent_next  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_tx_byte     <= '0;
            r_sent        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_tx_byte     <= w_tx_byte_next;
            r_sent        <= w_sent_next;
            r_timeout_err <= w_timeout_err_next;
            r_overflow    <= wrValid && w_fifo_full;
        end
    end

    assign txStart    = (r_state == START);
    assign txByte     = r_tx_byte;
    assign sent       = r_sent;
    assign timeoutErr = r_timeout_err;
    assign overflow   = r_overflow;
    assign wrReady    = !w_fifo_full;
    assign level      = w_fifo_level;
    assign empty      = w_fifo_empty;
    assign full       = w_fifo_full;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
// Directed bench for uart_tx_feeder (DEPTH=16, START_TIMEOUT=8).
// Each scenario task drives the DUT and checks against hand-derived values.
module tb_uart_tx_feeder;

    localparam int DEPTH         = 16;
    localparam int START_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wrValid = 1'b0;
    logic [7:0] wrData = 8'h00;
    logic       wrReady;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       txStart;
    logic [7:0] txByte;
    logic       txBusy = 1'b0;
    logic       sent;
    logic       timeoutErr;

    int n_checks = 0;
    int n_fail   = 0;

    // Traffic-run results
    logic [7:0] wr_q[$];
    logic [7:0] got_q[$];
    int sent_cnt;
    int ovf_cnt;
    int lvl_max;
    int full_occ;
    int full_lvl;
    bit traffic_done;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH         (DEPTH),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wrValid    (wrValid),
        .wrData     (wrData),
        .wrReady    (wrReady),
        .level      (level),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .txStart    (txStart),
        .txByte     (txByte),
        .txBusy     (txBusy),
        .sent       (sent),
        .timeoutErr (timeoutErr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes bytes from wr_q and emulates Uart8 busy (frame_len cycles per frame).
    // Captures txByte at each rising txStart into got_q.
    task automatic run_traffic(input int n_frames, input int frame_len, input int wr_gap,
                               input int max_cycles);
        int busy_cnt = 0;
        bit drove = 0;
        bit prev_start = 0;
        int accepted = 0;
        got_q.delete();
        sent_cnt = 0; ovf_cnt = 0; lvl_max = 0; full_occ = -1; full_lvl = -1;
        traffic_done = 0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (wr_q.size() > 0 && wrReady && (cyc % wr_gap) == 0) begin
                wrValid = 1'b1;
                wrData  = wr_q.pop_front();
                drove   = 1;
            end else begin
                wrValid = 1'b0;
                drove   = 0;
            end
            tick();
            if (drove) accepted++;
            if (txStart && !prev_start) begin
                got_q.push_back(txByte);
                $display("frame %0d start byte %02h level %0d", got_q.size(), txByte, level);
            end
            prev_start = txStart;
            if (sent) sent_cnt++;
            if (overflow) ovf_cnt++;
            if (int'(level) > lvl_max) lvl_max = int'(level);
            if (full && full_occ < 0) begin
                full_occ = accepted - got_q.size();
                full_lvl = int'(level);
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) txBusy = 1'b0;
            end else if (txStart && !txBusy) begin
                txBusy   = 1'b1;
                busy_cnt = frame_len;
            end
            if (sent_cnt >= n_frames && wr_q.size() == 0) begin
                traffic_done = 1;
                break;
            end
        end
        wrValid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; wrValid = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        txBusy = 1'b0;
        do_reset();
        n_checks++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL reset_txStart: got %b want 0", txStart); end
        n_checks++; if (txByte !== 8'h00) begin n_fail++; $display("FAIL reset_txByte: got %h want 00", txByte); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (wrReady !== 1'b1) begin n_fail++; $display("FAIL reset_wrReady: got %b want 1", wrReady); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if (sent !== 1'b0) begin n_fail++; $display("FAIL reset_sent: got %b want 0", sent); end
        n_checks++; if (timeoutErr !== 1'b0) begin n_fail++; $display("FAIL reset_timeoutErr: got %b want 0", timeoutErr); end
        $display("reset checked");
    endtask

    task automatic test_single_byte();
        wrValid = 1'b1; wrData = 8'h1E;
        tick();
        wrValid = 1'b0;
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_after_write: got %b want 0", empty); end
        n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level_after_write: got %0d want 1", level); end
        n_checks++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL single_txStart_early: got %b want 0", txStart); end
        tick();
        n_checks++; if (txStart !== 1'b1) begin n_fail++; $display("FAIL single_txStart: got %b want 1", txStart); end
        n_checks++; if (txByte !== 8'h1E) begin n_fail++; $display("FAIL single_txByte: got %h want 1e", txByte); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL single_level_after_pop: got %0d want 0", level); end
        tick(); tick();
        n_checks++; if (txStart !== 1'b1) begin n_fail++; $display("FAIL single_txStart_held: got %b want 1", txStart); end
        txBusy = 1'b1;
        tick();
        n_checks++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL single_txStart_release: got %b want 0", txStart); end
        tick();
        n_checks++; if (sent !== 1'b0) begin n_fail++; $display("FAIL single_sent_early: got %b want 0", sent); end
        txBusy = 1'b0;
        tick();
        n_checks++; if (sent !== 1'b1) begin n_fail++; $display("FAIL single_sent: got %b want 1", sent); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL single_level_end: got %0d want 0", level); end
        tick();
        n_checks++; if (sent !== 1'b0) begin n_fail++; $display("FAIL single_sent_pulse: got %b want 0", sent); end
        $display("single byte 1e checked");
    endtask

    task automatic test_burst_order();
        logic [7:0] exp_b[20] = '{8'd30, 8'd24, 8'd19, 8'd25, 8'd91, 8'd77, 8'd1, 8'd0, 8'd99, 8'd15,
                                  8'd100, 8'd128, 8'd255, 8'd254, 8'd0, 8'd10, 8'd43, 8'd149, 8'd7, 8'd2};
        txBusy = 1'b0;
        wr_q.delete();
        for (int i = 0; i < 20; i++) wr_q.push_back(exp_b[i]);
        run_traffic(20, 40, 1, 3000);
        n_checks++; if (traffic_done !== 1'b1) begin n_fail++; $display("FAIL burst_timeout: sent %0d want 20", sent_cnt); end
        n_checks++; if (full_occ != 16) begin n_fail++; $display("FAIL burst_full_occupancy: got %0d want 16", full_occ); end
        n_checks++; if (full_lvl != 16) begin n_fail++; $display("FAIL burst_full_level: got %0d want 16", full_lvl); end
        n_checks++; if (got_q.size() != 20) begin n_fail++; $display("FAIL burst_count: got %0d want 20", got_q.size()); end
        for (int i = 0; i < 20; i++) begin
            if (i < got_q.size()) begin
                n_checks++;
                if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL burst_byte%0d: got %h want %h", i, got_q[i], exp_b[i]); end
            end
        end
        n_checks++; if (sent_cnt != 20) begin n_fail++; $display("FAIL burst_sent: got %0d want 20", sent_cnt); end
        n_checks++; if (ovf_cnt != 0) begin n_fail++; $display("FAIL burst_overflow: got %0d want 0", ovf_cnt); end
        $display("burst of 20 checked");
    endtask

    task automatic test_overflow();
        int aa_cnt = 0;
        txBusy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wrValid = 1'b1; wrData = 8'h10 + 8'(i);
            tick();
        end
        wrValid = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level_full: got %0d want 16", level); end
        n_checks++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_blocks_pop: got %b want 0", txStart); end
        wrValid = 1'b1; wrData = 8'hAA;
        tick();
        wrValid = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level_hold: got %0d want 16", level); end
        n_checks++; if (wrReady !== 1'b0) begin n_fail++; $display("FAIL ovf_wrReady: got %b want 0", wrReady); end
        tick();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_width: got %b want 0", overflow); end
        txBusy = 1'b0;
        wr_q.delete();
        run_traffic(16, 4, 1, 1000);
        n_checks++; if (traffic_done !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_timeout: sent %0d want 16", sent_cnt); end
        n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] === 8'hAA) aa_cnt++;
        n_checks++; if (aa_cnt != 0) begin n_fail++; $display("FAIL ovf_dropped_byte_seen: got %0d want 0", aa_cnt); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== (8'h10 + 8'(i))) begin n_fail++; $display("FAIL ovf_drain_byte%0d: got %h want %h", i, got_q[i], 8'h10 + 8'(i)); end
        end
        $display("overflow checked");
    endtask

    task automatic test_timeout();
        int hi = 0;
        txBusy = 1'b0;
        wrValid = 1'b1; wrData = 8'h55;
        tick();
        wrValid = 1'b0;
        tick();
        n_checks++; if (txByte !== 8'h55) begin n_fail++; $display("FAIL tmo_txByte: got %h want 55", txByte); end
        for (int i = 0; i < 20 && txStart; i++) begin
            hi++;
            tick();
        end
        n_checks++; if (hi != 8) begin n_fail++; $display("FAIL tmo_start_cycles: got %0d want 8", hi); end
        n_checks++; if (timeoutErr !== 1'b1) begin n_fail++; $display("FAIL tmo_err_pulse: got %b want 1", timeoutErr); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL tmo_level: got %0d want 0", level); end
        tick();
        n_checks++; if (timeoutErr !== 1'b0) begin n_fail++; $display("FAIL tmo_err_width: got %b want 0", timeoutErr); end
        n_checks++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL tmo_back_to_idle: got %b want 0", txStart); end
        $display("timeout checked");
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        int bad = 0;
        int first_bad = -1;
        txBusy = 1'b0;
        wr_q.delete();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wr_q.push_back(8'(i * 7 + 3));
            exp_q.push_back(8'(i * 7 + 3));
        end
        run_traffic(3 * DEPTH, 5, 3, 5000);
        n_checks++; if (traffic_done !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout: sent %0d want 48", sent_cnt); end
        n_checks++; if (got_q.size() != 48) begin n_fail++; $display("FAIL wrap_count: got %0d want 48", got_q.size()); end
        for (int i = 0; i < 48 && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wrap_order: %0d wrong bytes, first at %0d", bad, first_bad); end
        n_checks++; if (lvl_max > DEPTH) begin n_fail++; $display("FAIL wrap_level_max: got %0d want <=16", lvl_max); end
        n_checks++; if (ovf_cnt != 0) begin n_fail++; $display("FAIL wrap_overflow: got %0d want 0", ovf_cnt); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL wrap_level_end: got %0d want 0", level); end
        $display("wrap-around of 48 checked, max level %0d", lvl_max);
    endtask

    task automatic test_reset_mid_frame();
        bit start_seen = 0;
        txBusy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wrValid = 1'b1; wrData = 8'hC0 + 8'(i);
            tick();
            if (txStart) txBusy = 1'b1;
        end
        wrValid = 1'b0;
        n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL rst_mid_level_before: got %0d want 5", level); end
        n_checks++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_wait: got %b want 0", txStart); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL rst_mid_level: got %0d want 0", level); end
        n_checks++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL rst_mid_txStart: got %b want 0", txStart); end
        n_checks++; if (txByte !== 8'h00) begin n_fail++; $display("FAIL rst_mid_txByte: got %h want 00", txByte); end
        wrValid = 1'b1; wrData = 8'h01;
        tick();
        wrValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (txStart) start_seen = 1;
        end
        n_checks++; if (start_seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start_while_busy: got 1 want 0"); end
        n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL rst_mid_level_held: got %0d want 1", level); end
        txBusy = 1'b0;
        tick();
        n_checks++; if (txStart !== 1'b1) begin n_fail++; $display("FAIL rst_mid_start_after_idle: got %b want 1", txStart); end
        n_checks++; if (txByte !== 8'h01) begin n_fail++; $display("FAIL rst_mid_txByte_after: got %h want 01", txByte); end
        txBusy = 1'b1;
        tick();
        txBusy = 1'b0;
        tick();
        n_checks++; if (sent !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sent: got %b want 1", sent); end
        tick();
        $display("reset mid-frame checked");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_order();
        test_overflow();
        test_timeout();
        test_wrap();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
